apb_spi_arbiter: RTL and testbench

- Round-robin scheduler that shares one apb_spi_master between NREQ requesters.
- Acts as the APB master in front of the SPI master:
  - programs the SPI master's registers for the winning request;
  - starts the transfer and waits for end-of-transfer (eot);
  - optionally reads back RX data;
  - returns a done pulse (and data) to the winner.
- Replaces hand-sequenced APB writes by software or bench.

---
 rtl/apb_spi_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_apb_spi_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_spi_arbiter.sv
// Round-robin arbiter that shares one APB SPI master between NREQ requesters.
// The winner's fields are latched, the SPI master is programmed over APB, the
// transfer is started, and the arbiter waits for eot. Read requests then fetch
// RXD. A one-cycle done pulse goes back to the winner.
// Optional build macro APB_SPI_ARB_TIMEOUT_EN: the eot wait is bounded by
// TIMEOUT_CYC cycles. On expiry START is cleared and done_o/err_o pulse together.
module apb_spi_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter logic [31:0] CTRL_IDLE   = 32'h0000_0800,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic               pclk_i,
  input  logic               prst_i,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ-1:0]    req_rd_i,
  input  logic [NREQ*8-1:0]  req_cmd_i,
  input  logic [NREQ*8-1:0]  req_cfg_i,
  input  logic [NREQ*8-1:0]  req_len_i,
  input  logic [NREQ*16-1:0] req_wdata_i,
  output logic [NREQ-1:0]    done_o,
  output logic [15:0]        rdata_o,
  output logic               err_o,
  output logic               busy_o,
  output logic               psel_o,
  output logic               penable_o,
  output logic               pwrite_o,
  output logic [31:0]        paddr_o,
  output logic [31:0]        pwdata_o,
  input  logic [31:0]        prdata_i,
  input  logic               pready_i,
  input  logic               eot_i
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {StIdle, StSetup, StAccess, StGap, StWaitEot, StDone} state_e;
  // One step per APB register access; Clr is the post-eot CTRL write.
  typedef enum logic [2:0] {
    StepCtrl, StepCmd, StepCfg, StepLen, StepTxd, StepStart, StepClr, StepRxd
  } step_e;

  state_e           state_q, state_d;
  step_e            step_q, step_d;
  logic [IdxW-1:0]  ptr_q, ptr_d, win_q, win_d;
  logic             rd_q, rd_d, to_q, to_d;
  logic [7:0]       cmd_q, cmd_d, cfg_q, cfg_d, len_q, len_d;
  logic [15:0]      wdata_q, wdata_d, rdata_q, rdata_d;
`ifdef APB_SPI_ARB_TIMEOUT_EN
  logic [15:0]      cnt_q, cnt_d;
`endif

  // Round-robin search: rotate requests so the pointer sits at bit 0.
  logic [2*NREQ-1:0] req_dbl;
  logic              any_req;
  logic [IdxW:0]     off, sum;
  logic [IdxW-1:0]   win_idx;
  always_comb begin
    req_dbl = {req_i, req_i} >> ptr_q;
    any_req = 1'b0;
    off     = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (!any_req && req_dbl[j]) begin
        any_req = 1'b1;
        off     = (IdxW+1)'(j);
      end
    end
    sum = {1'b0, ptr_q} + off;
    if (sum >= (IdxW+1)'(NREQ)) sum = sum - (IdxW+1)'(NREQ);
    win_idx = sum[IdxW-1:0];
  end

  // Mux out the fields of the requester that would win this cycle.
  logic        rd_sel;
  logic [7:0]  cmd_sel, cfg_sel, len_sel;
  logic [15:0] wdata_sel;
  always_comb begin
    rd_sel    = 1'b0;
    cmd_sel   = '0;
    cfg_sel   = '0;
    len_sel   = '0;
    wdata_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_idx == IdxW'(i)) begin
        rd_sel    = req_rd_i[i];
        cmd_sel   = req_cmd_i[i*8 +: 8];
        cfg_sel   = req_cfg_i[i*8 +: 8];
        len_sel   = req_len_i[i*8 +: 8];
        wdata_sel = req_wdata_i[i*16 +: 16];
      end
    end
  end

  // Next-state logic for the sequencer.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    rd_d    = rd_q;
    to_d    = to_q;
    cmd_d   = cmd_q;
    cfg_d   = cfg_q;
    len_d   = len_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef APB_SPI_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          win_d   = win_idx;
          ptr_d   = (win_idx == IdxW'(NREQ-1)) ? '0 : win_idx + 1'b1;
          rd_d    = rd_sel;
          cmd_d   = cmd_sel;
          cfg_d   = cfg_sel;
          len_d   = len_sel;
          wdata_d = wdata_sel;
          to_d    = 1'b0;
          step_d  = StepCtrl;
          state_d = StSetup;
        end
      end
      StSetup: state_d = StAccess;
      StAccess: begin
        if (pready_i) begin
          if (step_q == StepRxd) rdata_d = prdata_i[15:0];
          unique case (step_q)
            StepCtrl:  step_d = StepCmd;
            StepCmd:   step_d = StepCfg;
            StepCfg:   step_d = StepLen;
            StepLen:   step_d = rd_q ? StepStart : StepTxd;
            StepTxd:   step_d = StepStart;
            StepStart: step_d = StepClr;
            StepClr:   step_d = StepRxd;
            StepRxd:   step_d = StepCtrl;
          endcase
          if (step_q == StepStart) begin
            state_d = StWaitEot;
`ifdef APB_SPI_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else if (step_q == StepRxd || (step_q == StepClr && (!rd_q || to_q))) begin
            state_d = StDone;
          end else begin
            state_d = StGap;
          end
        end
      end
      // Idle bus cycle between accesses.
      StGap: state_d = StSetup;
      StWaitEot: begin
        if (eot_i) begin
          state_d = StSetup;
`ifdef APB_SPI_ARB_TIMEOUT_EN
        end else if (cnt_q == 16'(TIMEOUT_CYC - 1)) begin
          to_d    = 1'b1;
          state_d = StSetup;
        end else begin
          cnt_d = cnt_q + 16'd1;
`endif
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      state_q <= StIdle;
      step_q  <= StepCtrl;
      ptr_q   <= '0;
      win_q   <= '0;
      rd_q    <= 1'b0;
      to_q    <= 1'b0;
      cmd_q   <= '0;
      cfg_q   <= '0;
      len_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef APB_SPI_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      rd_q    <= rd_d;
      to_q    <= to_d;
      cmd_q   <= cmd_d;
      cfg_q   <= cfg_d;
      len_q   <= len_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef APB_SPI_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // APB and requester outputs decoded from the registered state.
  logic apb_act;
  always_comb begin
    apb_act   = (state_q == StSetup) || (state_q == StAccess);
    psel_o    = apb_act;
    penable_o = (state_q == StAccess);
    pwrite_o  = 1'b0;
    paddr_o   = '0;
    pwdata_o  = '0;
    if (apb_act) begin
      pwrite_o = 1'b1;
      unique case (step_q)
        StepCtrl:  begin paddr_o = 32'h14; pwdata_o = CTRL_IDLE; end
        StepCmd:   begin paddr_o = 32'h00; pwdata_o = {24'h0, cmd_q}; end
        StepCfg:   begin paddr_o = 32'h04; pwdata_o = {24'h0, cfg_q}; end
        StepLen:   begin paddr_o = 32'h08; pwdata_o = {24'h0, len_q}; end
        StepTxd:   begin paddr_o = 32'h0c; pwdata_o = {16'h0, wdata_q}; end
        StepStart: begin paddr_o = 32'h14; pwdata_o = CTRL_IDLE | 32'h1; end
        StepClr:   begin paddr_o = 32'h14; pwdata_o = CTRL_IDLE; end
        StepRxd:   begin paddr_o = 32'h10; pwrite_o = 1'b0; end
      endcase
    end
    done_o = '0;
    if (state_q == StDone) done_o[win_q] = 1'b1;
    busy_o  = (state_q != StIdle);
    rdata_o = rdata_q;
`ifdef APB_SPI_ARB_TIMEOUT_EN
    err_o = (state_q == StDone) && to_q;
`else
    err_o = 1'b0;
`endif
  end

endmodule

// File: tb/tb_apb_spi_arbiter.sv
// Directed bench for apb_spi_arbiter: an APB slave model with programmable
// wait states logs every completed access; tasks check the logs inline.
module tb_apb_spi_arbiter;
  localparam int unsigned NREQ = 4;

  logic              pclk = 1'b0;
  logic              prst = 1'b1;
  logic [NREQ-1:0]   req = '0, req_rd = '0;
  logic [NREQ*8-1:0] req_cmd = '0, req_cfg = '0, req_len = '0;
  logic [NREQ*16-1:0] req_wdata = '0;
  logic [NREQ-1:0]   done_o;
  logic [15:0]       rdata_o;
  logic              err_o, busy_o, psel_o, penable_o, pwrite_o;
  logic [31:0]       paddr_o, pwdata_o;
  logic [31:0]       prdata = '0;
  logic              pready = 1'b0;
  logic              eot = 1'b0;

  apb_spi_arbiter #(.NREQ(NREQ), .CTRL_IDLE(32'h800), .TIMEOUT_CYC(64)) dut (
    .pclk_i(pclk), .prst_i(prst), .req_i(req), .req_rd_i(req_rd),
    .req_cmd_i(req_cmd), .req_cfg_i(req_cfg), .req_len_i(req_len),
    .req_wdata_i(req_wdata), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o),
    .busy_o(busy_o), .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .prdata_i(prdata), .pready_i(pready),
    .eot_i(eot)
  );

  always #5 pclk = ~pclk;

  int total = 0, bad = 0;
  logic [31:0] log_addr[$], log_data[$];
  logic        log_wr[$];
  int          pen_len[$];
  logic [NREQ-1:0] done_q[$];
  logic [15:0] done_rd[$];
  logic        done_err[$];
  int ws = 0, cur_ws = 0, stab_err = 0, gap_err = 0;
  logic prev_psel = 1'b0, setup_wr = 1'b0;
  logic [31:0] setup_addr = '0, setup_data = '0;

  // APB slave: pready after ws wait cycles; logs accesses and done pulses.
  always @(negedge pclk) begin
    if (psel_o && penable_o) begin
      if (paddr_o !== setup_addr || pwdata_o !== setup_data || pwrite_o !== setup_wr)
        stab_err++;
      if (cur_ws >= ws) begin
        pready = 1'b1;
        log_addr.push_back(paddr_o);
        log_data.push_back(pwdata_o);
        log_wr.push_back(pwrite_o);
        pen_len.push_back(cur_ws + 1);
        cur_ws = 0;
      end else begin
        pready = 1'b0;
        cur_ws++;
      end
    end else begin
      pready = 1'b0;
      cur_ws = 0;
      if (psel_o) begin
        if (prev_psel) gap_err++;
        setup_addr = paddr_o;
        setup_data = pwdata_o;
        setup_wr   = pwrite_o;
      end
    end
    prev_psel = psel_o;
    if (done_o != '0) begin
      done_q.push_back(done_o);
      done_rd.push_back(rdata_o);
      done_err.push_back(err_o);
    end
  end

  task automatic tick();
    @(negedge pclk);
    #1;
  endtask

  task automatic clear_logs();
    log_addr.delete(); log_data.delete(); log_wr.delete(); pen_len.delete();
    done_q.delete(); done_rd.delete(); done_err.delete();
    stab_err = 0; gap_err = 0;
  endtask

  task automatic do_reset();
    prst = 1'b1;
    repeat (2) tick();
    prst = 1'b0;
  endtask

  task automatic load(input int i, input logic rd, input logic [7:0] cmd, input logic [7:0] cfg,
                      input logic [7:0] len, input logic [15:0] wd);
    req_rd[i] = rd;
    req_cmd[i*8 +: 8] = cmd;
    req_cfg[i*8 +: 8] = cfg;
    req_len[i*8 +: 8] = len;
    req_wdata[i*16 +: 16] = wd;
  endtask

  task automatic wait_busy(input string name, input int budget);
    int n = 0;
    while (!busy_o && n < budget) begin tick(); n++; end
    if (!busy_o) begin
      total++; bad++;
      $display("FAIL %s: busy_o never rose within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_log(input string name, input int cnt, input int budget);
    int n = 0;
    while (log_addr.size() < cnt && n < budget) begin tick(); n++; end
    if (log_addr.size() < cnt) begin
      total++; bad++;
      $display("FAIL %s: got %0d accesses, want %0d", name, log_addr.size(), cnt);
    end
  endtask

  task automatic wait_done(input string name, input int cnt, input int budget);
    int n = 0;
    while (done_q.size() < cnt && n < budget) begin tick(); n++; end
    if (done_q.size() < cnt) begin
      total++; bad++;
      $display("FAIL %s: got %0d done pulses, want %0d", name, done_q.size(), cnt);
    end
  endtask

  task automatic test_reset();
    prst = 1'b1;
    repeat (3) tick();
    total++;
    if ({done_o, rdata_o, err_o, busy_o, psel_o, penable_o, pwrite_o} !== '0 ||
        paddr_o !== '0 || pwdata_o !== '0) begin
      bad++;
      $display("FAIL reset_outputs: done=%b rdata=%h err=%b busy=%b psel=%b pen=%b addr=%h want all 0",
               done_o, rdata_o, err_o, busy_o, psel_o, penable_o, paddr_o);
    end
    prst = 1'b0;
    repeat (2) tick();
    total++;
    if (busy_o !== 1'b0 || psel_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: busy=%b psel=%b want 0/0", busy_o, psel_o);
    end
  endtask

  task automatic test_single_write();
    logic [31:0] ea[7] = '{32'h14, 32'h00, 32'h04, 32'h08, 32'h0c, 32'h14, 32'h14};
    logic [31:0] ed[7] = '{32'h800, 32'h0b, 32'h03, 32'h10, 32'h1234, 32'h801, 32'h800};
    clear_logs();
    load(0, 1'b0, 8'h0b, 8'h03, 8'h10, 16'h1234);
    req = 4'b0001;
    wait_busy("write_busy", 10);
    req = '0;
    wait_log("write_prog", 6, 100);
    repeat (5) tick();
    total++;
    if (done_q.size() != 0 || busy_o !== 1'b1 || log_addr.size() != 6) begin
      bad++;
      $display("FAIL write_wait_eot: done=%0d busy=%b acc=%0d want 0/1/6",
               done_q.size(), busy_o, log_addr.size());
    end
    eot = 1'b1;
    wait_done("write_done", 1, 100);
    eot = 1'b0;
    repeat (3) tick();
    total++;
    if (log_addr.size() != 7) begin
      bad++;
      $display("FAIL write_count: got %0d accesses want 7", log_addr.size());
    end
    for (int k = 0; k < 7 && k < log_addr.size(); k++) begin
      total++;
      if (log_addr[k] !== ea[k] || log_data[k] !== ed[k] || log_wr[k] !== 1'b1) begin
        bad++;
        $display("FAIL write_seq[%0d]: got %h/%h w=%b want %h/%h w=1",
                 k, log_addr[k], log_data[k], log_wr[k], ea[k], ed[k]);
      end
    end
    total++;
    if (done_q.size() != 1 || done_q[0] !== 4'b0001 || done_err[0] !== 1'b0) begin
      bad++;
      $display("FAIL write_done_vec: got n=%0d want one pulse 0001 err 0", done_q.size());
    end
  endtask

  task automatic test_single_read();
    logic [31:0] ea[7] = '{32'h14, 32'h00, 32'h04, 32'h08, 32'h14, 32'h14, 32'h10};
    logic [31:0] ed[7] = '{32'h800, 32'h0a, 32'h05, 32'h10, 32'h801, 32'h800, 32'h0};
    clear_logs();
    load(2, 1'b1, 8'h0a, 8'h05, 8'h10, 16'hdead);
    prdata = 32'h0000_48d1;
    eot = 1'b1;
    req = 4'b0100;
    wait_busy("read_busy", 10);
    req = '0;
    wait_done("read_done", 1, 150);
    eot = 1'b0;
    repeat (4) tick();
    total++;
    if (log_addr.size() != 7) begin
      bad++;
      $display("FAIL read_count: got %0d accesses want 7", log_addr.size());
    end
    for (int k = 0; k < 7 && k < log_addr.size(); k++) begin
      total++;
      if (log_addr[k] !== ea[k] || log_wr[k] !== (k != 6) || (k != 6 && log_data[k] !== ed[k])) begin
        bad++;
        $display("FAIL read_seq[%0d]: got %h/%h w=%b want %h/%h", k, log_addr[k], log_data[k],
                 log_wr[k], ea[k], ed[k]);
      end
    end
    total++;
    if (done_q.size() != 1 || done_q[0] !== 4'b0100 || done_rd[0] !== 16'h48d1) begin
      bad++;
      $display("FAIL read_done: got n=%0d want done 0100 with rdata 48d1", done_q.size());
    end
    prdata = 32'h0;
    total++;
    if (rdata_o !== 16'h48d1) begin
      bad++;
      $display("FAIL read_hold: got rdata %h want 48d1", rdata_o);
    end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp4[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [NREQ-1:0] exp3[3] = '{4'b0001, 4'b0010, 4'b1000};
    int n;
    for (int i = 0; i < 4; i++) load(i, 1'b0, 8'(i), 8'h1, 8'h8, 16'(i * 3));
    do_reset();
    clear_logs();
    eot = 1'b1;
    req = 4'b1111;
    n = 0;
    while (done_q.size() < 5 && n < 500) begin tick(); n++; end
    req = '0;
    repeat (40) tick();
    total++;
    if (done_q.size() != 5 || log_addr.size() != 35) begin
      bad++;
      $display("FAIL rr_count: got %0d grants %0d accesses want 5/35", done_q.size(), log_addr.size());
    end
    for (int k = 0; k < 5 && k < done_q.size(); k++) begin
      total++;
      if (done_q[k] !== exp4[k]) begin
        bad++;
        $display("FAIL rr_order[%0d]: got %b want %b", k, done_q[k], exp4[k]);
      end
    end
    do_reset();
    clear_logs();
    req = 4'b1011;
    n = 0;
    while (done_q.size() < 3 && n < 400) begin tick(); n++; end
    req = '0;
    repeat (40) tick();
    eot = 1'b0;
    total++;
    if (done_q.size() != 3) begin
      bad++;
      $display("FAIL rr1011_count: got %0d grants want 3", done_q.size());
    end
    for (int k = 0; k < 3 && k < done_q.size(); k++) begin
      total++;
      if (done_q[k] !== exp3[k]) begin
        bad++;
        $display("FAIL rr1011_order[%0d]: got %b want %b", k, done_q[k], exp3[k]);
      end
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] ea[7] = '{32'h14, 32'h00, 32'h04, 32'h08, 32'h0c, 32'h14, 32'h14};
    logic [31:0] ed[7] = '{32'h800, 32'h9f, 32'h01, 32'h20, 32'hbeef, 32'h801, 32'h800};
    clear_logs();
    load(1, 1'b0, 8'h9f, 8'h01, 8'h20, 16'hbeef);
    ws = 3;
    eot = 1'b1;
    req = 4'b0010;
    wait_busy("ws_busy", 10);
    req = '0;
    wait_done("ws_done", 1, 400);
    eot = 1'b0;
    repeat (3) tick();
    ws = 0;
    total++;
    if (log_addr.size() != 7 || done_q.size() != 1 || done_q[0] !== 4'b0010) begin
      bad++;
      $display("FAIL ws_count: got %0d accesses %0d pulses want 7 accesses one 0010 pulse",
               log_addr.size(), done_q.size());
    end
    for (int k = 0; k < 7 && k < log_addr.size(); k++) begin
      total++;
      if (log_addr[k] !== ea[k] || log_data[k] !== ed[k] || pen_len[k] != 4) begin
        bad++;
        $display("FAIL ws_seq[%0d]: got %h/%h penable %0d cycles want %h/%h 4",
                 k, log_addr[k], log_data[k], pen_len[k], ea[k], ed[k]);
      end
    end
    total++;
    if (stab_err != 0 || gap_err != 0) begin
      bad++;
      $display("FAIL ws_stable: got %0d unstable cycles %0d back-to-back setups want 0/0",
               stab_err, gap_err);
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    load(1, 1'b0, 8'h02, 8'h00, 8'h08, 16'h00aa);
    eot = 1'b0;
    req = 4'b0010;
    wait_busy("mid_busy", 10);
    req = '0;
    wait_log("mid_prog", 6, 100);
    repeat (3) tick();
    prst = 1'b1;
    tick();
    total++;
    if (psel_o !== 1'b0 || penable_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: psel=%b pen=%b busy=%b want 0/0/0", psel_o, penable_o, busy_o);
    end
    prst = 1'b0;
    eot = 1'b1;
    repeat (10) tick();
    total++;
    if (done_q.size() != 0) begin
      bad++;
      $display("FAIL mid_no_done: got %0d pulses want 0", done_q.size());
    end
    // Pointer was 2 before reset; from 0 the winner of 1010 is requester 1.
    req = 4'b1010;
    wait_busy("mid_rearb_busy", 10);
    req = '0;
    wait_done("mid_rearb", 1, 150);
    eot = 1'b0;
    total++;
    if (done_q.size() < 1 || done_q[0] !== 4'b0010) begin
      bad++;
      $display("FAIL mid_ptr: got n=%0d want first grant 0010", done_q.size());
    end
  endtask

`ifdef APB_SPI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [15:0] keep;
    clear_logs();
    load(2, 1'b1, 8'h03, 8'h00, 8'h08, 16'h0);
    prdata = 32'h0000_5a5a;
    eot = 1'b1;
    req = 4'b0100;
    wait_busy("to_pre_busy", 10);
    req = '0;
    wait_done("to_pre", 1, 150);
    eot = 1'b0;
    repeat (2) tick();
    keep = rdata_o;
    clear_logs();
    prdata = 32'h0000_1111;
    load(3, 1'b1, 8'h05, 8'h00, 8'h08, 16'h0);
    req = 4'b1000;
    wait_busy("to_busy", 10);
    req = '0;
    wait_done("to_done", 1, 300);
    repeat (2) tick();
    total++;
    if (done_q.size() != 1 || done_q[0] !== 4'b1000 || done_err[0] !== 1'b1) begin
      bad++;
      $display("FAIL to_pulse: got n=%0d want done 1000 with err 1", done_q.size());
    end
    total++;
    if (log_addr.size() != 6 || log_addr[5] !== 32'h14 || log_data[5] !== 32'h800) begin
      bad++;
      $display("FAIL to_clr: got %0d accesses want 6 ending 14/800", log_addr.size());
    end
    total++;
    if (keep !== 16'h5a5a || rdata_o !== keep) begin
      bad++;
      $display("FAIL to_rdata: got %h want 5a5a", rdata_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_round_robin();
    test_wait_states();
    test_reset_mid();
`ifdef APB_SPI_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
